// File: rtl/prio_irq_encoder_pkg.sv
// Shared definitions for the prio_irq_encoder block.
//   irq_state_e : grant FSM state encoding (IDLE = 0, GRANT = 1)
//   MODE_*      : priority scheme selector values
//   EDGE_*      : request capture scheme selector values
//   rr_after()  : round-robin pointer value after a grant to a given line
package prio_irq_encoder_pkg;

  typedef enum logic {
    IRQ_S_IDLE  = 1'b0,
    IRQ_S_GRANT = 1'b1
  } irq_state_e;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;
  localparam int EDGE_LEVEL = 0;
  localparam int EDGE_RISE  = 1;

  // The line just served drops to lowest priority: the search for the next
  // round starts one below it, wrapping at n-1 rather than at 2^W-1.
  function automatic int rr_after(input int id, input int n);
    return (id == 0) ? n - 1 : id - 1;
  endfunction

endpackage

// File: rtl/prio_irq_encoder_if.sv
// Grant handshake between the encoder and the interrupt-ack consumer.
//   grant_valid : grant_id is valid; held until acknowledged
//   grant_id    : index of the granted source
//   grant_ack   : consumer accepts the current grant
// master = encoder side, slave = consumer side.
interface prio_irq_encoder_if #(
  parameter int N = 8
);
  localparam int W = (N > 1) ? $clog2(N) : 1;

  logic         grant_valid;
  logic [W-1:0] grant_id;
  logic         grant_ack;

  modport master (output grant_valid, output grant_id, input grant_ack);
  modport slave  (input grant_valid, input grant_id, output grant_ack);

endinterface

// File: rtl/prio_irq_encoder_pick.sv
// Combinational priority pick over an N-bit vector.
//   vec   : candidate lines
//   start : highest-priority index; priority falls start, start-1, ..., 0,
//           N-1, ..., start+1 (modulo N)
//   id    : index of the winning line (0 when none)
//   found : at least one line of vec is set
module prio_irq_encoder_pick #(
  parameter int N = 8,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic [W-1:0] id,
  output logic         found
);

  // Index at priority rank k, wrapping at N so non-power-of-2 N never
  // produces an index >= N.
  function automatic logic [W-1:0] slot(input logic [W-1:0] s, input int k);
    int idx;
    idx = int'(s) - k;
    if (idx < 0) idx = idx + N;
    return W'(idx);
  endfunction

  // Walk from the lowest rank to the highest so the last hit written is the
  // highest-priority set line.
  always_comb begin
    id    = '0;
    found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (vec[slot(start, k)]) begin
        id    = slot(start, k);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_irq_encoder.sv
// Registered, handshaked priority interrupt encoder.
//   clk, rst : clock (rising edge), synchronous active-high reset
//   req      : request lines, bit i = source i
//   mask     : 1 = source i not eligible for grant (still captured when EDGE=1)
//   irq      : grant handshake (grant_valid / grant_id out, grant_ack in)
//   pending  : registered pending vector
//   idle     : no eligible pending source
// MODE = 0 fixed priority (highest index wins), 1 = round-robin.
// EDGE = 0 level capture, 1 = rising-edge capture sticky until acknowledged.
module prio_irq_encoder
  import prio_irq_encoder_pkg::*;
#(
  parameter int N    = 8,
  parameter int MODE = MODE_FIXED,
  parameter int EDGE = EDGE_LEVEL
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req,
  input  logic [N-1:0]          mask,
  prio_irq_encoder_if.master    irq,
  output logic [N-1:0]          pending,
  output logic                  idle
);

  localparam int W = (N > 1) ? $clog2(N) : 1;

  irq_state_e   state_q, state_d;
  logic [N-1:0] pending_q, pending_d, req_d, elig, clr;
  logic [W-1:0] grant_id_q, grant_id_d, rr_ptr_q, rr_ptr_d;
  logic [W-1:0] start, winner;
  logic         found, ack_eff;

  // Selection looks only at captured, unmasked requests.
  assign elig  = pending_q & ~mask;
  assign start = (MODE == MODE_RR) ? rr_ptr_q : W'(N - 1);

  prio_irq_encoder_pick #(.N(N), .W(W)) u_pick (
    .vec   (elig),
    .start (start),
    .id    (winner),
    .found (found)
  );

  // An ack only counts while a grant is actually being offered.
  assign ack_eff = (state_q == IRQ_S_GRANT) && irq.grant_ack;
  assign clr     = ack_eff ? (N'(1) << grant_id_q) : '0;

  // Capture: in edge mode a new rising edge on the line being acked is
  // kept, so the set term is applied after the clear.
  always_comb begin
    pending_d = req;
    if (EDGE == EDGE_RISE) pending_d = (pending_q & ~clr) | (req & ~req_d);
  end

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      IRQ_S_IDLE: begin
        if (found) begin
          grant_id_d = winner;
          state_d    = IRQ_S_GRANT;
        end
      end
      IRQ_S_GRANT: begin
        // Grant is held regardless of req/mask until the consumer acks.
        if (irq.grant_ack) begin
          state_d = IRQ_S_IDLE;
          if (MODE == MODE_RR) rr_ptr_d = W'(rr_after(int'(grant_id_q), N));
        end
      end
      default: state_d = IRQ_S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IRQ_S_IDLE;
      pending_q  <= '0;
      req_d      <= '0;
      grant_id_q <= '0;
      rr_ptr_q   <= W'(N - 1);
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      req_d      <= req;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign irq.grant_valid = (state_q == IRQ_S_GRANT);
  assign irq.grant_id    = grant_id_q;
  assign pending         = pending_q;
  assign idle            = ~|elig;

endmodule

// File: tb/tb_prio_irq_encoder.sv
module tb_prio_irq_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // u0: N=8 fixed level; u1: N=8 round-robin; u2: N=8 fixed edge; u3: N=5 round-robin
  logic       rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1, rst3 = 1'b1;
  logic [7:0] req0 = '0, req1 = '0, req2 = '0;
  logic [7:0] mask0 = '0, mask1 = '0, mask2 = '0;
  logic [4:0] req3 = '0, mask3 = '0;
  logic [7:0] pend0, pend1, pend2;
  logic [4:0] pend3;
  logic       idle0, idle1, idle2, idle3;

  prio_irq_encoder_if #(.N(8)) if0 ();
  prio_irq_encoder_if #(.N(8)) if1 ();
  prio_irq_encoder_if #(.N(8)) if2 ();
  prio_irq_encoder_if #(.N(5)) if3 ();

  prio_irq_encoder #(.N(8), .MODE(0), .EDGE(0)) u0 (
    .clk(clk), .rst(rst0), .req(req0), .mask(mask0), .irq(if0.master),
    .pending(pend0), .idle(idle0));
  prio_irq_encoder #(.N(8), .MODE(1), .EDGE(0)) u1 (
    .clk(clk), .rst(rst1), .req(req1), .mask(mask1), .irq(if1.master),
    .pending(pend1), .idle(idle1));
  prio_irq_encoder #(.N(8), .MODE(0), .EDGE(1)) u2 (
    .clk(clk), .rst(rst2), .req(req2), .mask(mask2), .irq(if2.master),
    .pending(pend2), .idle(idle2));
  prio_irq_encoder #(.N(5), .MODE(1), .EDGE(0)) u3 (
    .clk(clk), .rst(rst3), .req(req3), .mask(mask3), .irq(if3.master),
    .pending(pend3), .idle(idle3));

  typedef struct {
    logic [7:0] req;
    logic [7:0] mask;
    logic       ack;
    logic       gv;
    logic [2:0] id;
    logic       idle;
    logic [7:0] pend;
  } vec_t;

  typedef struct {
    logic       gv;
    logic [2:0] id;
    logic       idle;
    logic [7:0] pend;
  } exp_t;

  vec_t vt[19];
  exp_t sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    int   exp_id;
    if0.grant_ack = 1'b0;
    if1.grant_ack = 1'b0;
    if2.grant_ack = 1'b0;
    if3.grant_ack = 1'b0;

    //             req    mask   ack   gv    id    idle  pend   (outputs after the edge)
    vt[0]  = '{8'hB0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 8'hB0};
    vt[1]  = '{8'hB0, 8'h00, 1'b0, 1'b1, 3'd7, 1'b0, 8'hB0};
    vt[2]  = '{8'h30, 8'h00, 1'b1, 1'b0, 3'd7, 1'b0, 8'h30};
    vt[3]  = '{8'h30, 8'h00, 1'b0, 1'b1, 3'd5, 1'b0, 8'h30};
    vt[4]  = '{8'h01, 8'h00, 1'b1, 1'b0, 3'd5, 1'b0, 8'h01};
    vt[5]  = '{8'h01, 8'h00, 1'b0, 1'b1, 3'd0, 1'b0, 8'h01};
    vt[6]  = '{8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 1'b1, 8'h00};
    vt[7]  = '{8'h81, 8'h80, 1'b0, 1'b0, 3'd0, 1'b0, 8'h81};
    vt[8]  = '{8'h81, 8'h80, 1'b0, 1'b1, 3'd0, 1'b0, 8'h81};
    vt[9]  = '{8'h81, 8'h01, 1'b0, 1'b1, 3'd0, 1'b0, 8'h81};
    vt[10] = '{8'h00, 8'h01, 1'b0, 1'b1, 3'd0, 1'b1, 8'h00};
    vt[11] = '{8'h80, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 8'h80};
    vt[12] = '{8'h80, 8'h00, 1'b0, 1'b1, 3'd7, 1'b0, 8'h80};
    vt[13] = '{8'h00, 8'h00, 1'b1, 1'b0, 3'd7, 1'b1, 8'h00};
    vt[14] = '{8'h00, 8'h00, 1'b1, 1'b0, 3'd7, 1'b1, 8'h00};
    vt[15] = '{8'h02, 8'h00, 1'b1, 1'b0, 3'd7, 1'b0, 8'h02};
    vt[16] = '{8'h02, 8'h00, 1'b1, 1'b1, 3'd1, 1'b0, 8'h02};
    vt[17] = '{8'h02, 8'h00, 1'b0, 1'b1, 3'd1, 1'b0, 8'h02};
    vt[18] = '{8'h00, 8'h00, 1'b1, 1'b0, 3'd1, 1'b1, 8'h00};

    // ---- u0: reset state, then the vector table
    step();
    chk("u0 reset gv", if0.grant_valid, 1'b0);
    chk("u0 reset id", if0.grant_id, 3'd0);
    chk("u0 reset pend", pend0, 8'h00);
    chk("u0 reset idle", idle0, 1'b1);
    rst0 = 1'b0;
    for (int i = 0; i < 19; i++) begin
      req0 = vt[i].req;
      mask0 = vt[i].mask;
      if0.grant_ack = vt[i].ack;
      sbq.push_back('{vt[i].gv, vt[i].id, vt[i].idle, vt[i].pend});
      step();
      e = sbq.pop_front();
      chk($sformatf("u0 row%0d gv", i), if0.grant_valid, e.gv);
      chk($sformatf("u0 row%0d id", i), if0.grant_id, e.id);
      chk($sformatf("u0 row%0d idle", i), idle0, e.idle);
      chk($sformatf("u0 row%0d pend", i), pend0, e.pend);
    end
    if0.grant_ack = 1'b0;

    // ---- u1: round-robin with all lines held
    rst1 = 1'b0;
    req1 = 8'hFF;
    step();
    chk("u1 first pend", pend1, 8'hFF);
    chk("u1 first gv", if1.grant_valid, 1'b0);
    step();
    chk("u1 grant0 gv", if1.grant_valid, 1'b1);
    chk("u1 grant0 id", if1.grant_id, 3'd7);
    for (int k = 1; k <= 9; k++) begin
      if1.grant_ack = 1'b1;
      step();
      chk($sformatf("u1 bubble%0d gv", k), if1.grant_valid, 1'b0);
      if1.grant_ack = 1'b0;
      step();
      exp_id = (7 - k + 16) % 8;
      chk($sformatf("u1 grant%0d gv", k), if1.grant_valid, 1'b1);
      chk($sformatf("u1 grant%0d id", k), if1.grant_id, exp_id);
    end

    // ---- u2: edge capture, sticky pending, set-over-clear
    rst2 = 1'b0;
    req2 = 8'h40;
    step();
    chk("u2 pulse6 pend", pend2, 8'h40);
    req2 = 8'h00;
    step();
    chk("u2 grant6 gv", if2.grant_valid, 1'b1);
    chk("u2 grant6 id", if2.grant_id, 3'd6);
    req2 = 8'h08;
    step();
    chk("u2 pulse3 pend", pend2, 8'h48);
    req2 = 8'h00;
    step();
    chk("u2 sticky3 pend", pend2, 8'h48);
    chk("u2 hold6 id", if2.grant_id, 3'd6);
    if2.grant_ack = 1'b1;
    step();
    chk("u2 ack6 gv", if2.grant_valid, 1'b0);
    chk("u2 ack6 pend", pend2, 8'h08);
    if2.grant_ack = 1'b0;
    step();
    chk("u2 grant3 gv", if2.grant_valid, 1'b1);
    chk("u2 grant3 id", if2.grant_id, 3'd3);
    if2.grant_ack = 1'b1;
    req2 = 8'h08;
    step();
    chk("u2 ackpulse gv", if2.grant_valid, 1'b0);
    chk("u2 ackpulse pend", pend2, 8'h08);
    if2.grant_ack = 1'b0;
    req2 = 8'h00;
    step();
    chk("u2 regrant3 id", if2.grant_id, 3'd3);
    chk("u2 regrant3 gv", if2.grant_valid, 1'b1);
    if2.grant_ack = 1'b1;
    step();
    chk("u2 clear pend", pend2, 8'h00);
    if2.grant_ack = 1'b0;
    mask2 = 8'h04;
    req2 = 8'h04;
    step();
    chk("u2 masked capture pend", pend2, 8'h04);
    chk("u2 masked idle", idle2, 1'b1);
    req2 = 8'h00;
    step();
    chk("u2 masked no grant", if2.grant_valid, 1'b0);
    mask2 = 8'h00;
    step();
    chk("u2 unmask grant gv", if2.grant_valid, 1'b1);
    chk("u2 unmask grant id", if2.grant_id, 3'd2);

    // ---- u3: N=5 round-robin wrap, then reset mid-grant
    rst3 = 1'b0;
    req3 = 5'b11111;
    step();
    step();
    chk("u3 grant0 id", if3.grant_id, 3'd4);
    for (int k = 1; k <= 5; k++) begin
      if3.grant_ack = 1'b1;
      step();
      chk($sformatf("u3 bubble%0d gv", k), if3.grant_valid, 1'b0);
      if3.grant_ack = 1'b0;
      step();
      exp_id = (4 - k + 10) % 5;
      chk($sformatf("u3 grant%0d id", k), if3.grant_id, exp_id);
    end
    chk("u3 before rst gv", if3.grant_valid, 1'b1);
    rst3 = 1'b1;
    step();
    chk("u3 rst gv", if3.grant_valid, 1'b0);
    chk("u3 rst pend", pend3, 5'b00000);
    chk("u3 rst idle", idle3, 1'b1);
    rst3 = 1'b0;
    step();
    step();
    chk("u3 after rst gv", if3.grant_valid, 1'b1);
    chk("u3 after rst id", if3.grant_id, 3'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
